l2b_sio_rtn_assembler: RTL and testbench

Per-bank receive stage for the L2-to-SIO read-return stream, sitting directly downstream of the L2 bank output and feeding the SIO outbound packet logic. It captures one header (ctag) beat plus NUM_BEATS 32-bit data beats, checks beat parity, accumulates the L2 uncorrectable-error flag, and presents each completed line through a 2-entry valid/ready buffer. The L2 bank cannot be stalled, so buffer overflow and framing violations are detected and reported as sticky errors.

---
 rtl/l2_sio_pkg.sv | 23 ++
 rtl/l2b_sio_line_fifo.sv | 55 +++++
 rtl/l2b_sio_rtn_assembler.sv | 151 +++++++++++++++
 tb/tb_l2b_sio_rtn_assembler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_sio_pkg.sv
// Shared types and helpers for the L2-to-SIO read-return path.
package l2_sio_pkg;

    localparam int L2_NUM_BEATS = 16;

    typedef enum logic {
        ST_IDLE,
        ST_DATA
    } asm_state_t;

    typedef struct packed {
        logic [31:0]                ctag;
        logic [32*L2_NUM_BEATS-1:0] data;
        logic                       ue;
        logic                       pe;
    } line_t;

    // Even parity: the stored bit is the XOR of the 16 bits it covers.
    function automatic logic even_par16(input logic [15:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/l2b_sio_line_fifo.sv
// Two-entry valid/ready line buffer; a push into a full buffer without a same-cycle pop is dropped and flagged.
module l2b_sio_line_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             iol2clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_data,
    output logic             ovf
);

    logic [WIDTH-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             pop;
    logic             push;
    logic             full;

    assign full   = (count_q == 2'd2);
    assign rd_vld = (count_q != 2'd0);
    assign pop    = rd_vld & rd_rdy;
    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign push   = wr_en & (~full | pop);
    assign ovf    = wr_en & full & ~pop;
    assign rd_data = mem_q[rd_ptr_q];

    always_ff @(posedge iol2clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/l2b_sio_rtn_assembler.sv
// Per-bank receive stage: assembles a ctag header plus NUM_BEATS data beats into a line,
// accumulates parity/UE status, and buffers completed lines for the SIO outbound logic.
module l2b_sio_rtn_assembler
    import l2_sio_pkg::*;
#(
    parameter int NUM_BEATS = L2_NUM_BEATS,
    parameter int BANK_ID   = 0
) (
    input  logic                   iol2clk,
    input  logic                   reset,
    input  logic                   l2b_sio_ctag_vld,
    input  logic [31:0]            l2b_sio_data,
    input  logic [1:0]             l2b_sio_parity,
    input  logic                   l2b_sio_ue_err,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [31:0]            out_ctag,
    output logic [32*NUM_BEATS-1:0] out_data,
    output logic                   out_ue,
    output logic                   out_pe,
    output logic [2:0]             out_bank,
    output logic                   ovf_err,
    output logic                   proto_err,
    input  logic                   err_clr
);

    localparam int CNT_W  = $clog2(NUM_BEATS);
    localparam int DATA_W = 32 * NUM_BEATS;
    localparam int LINE_W = 32 + DATA_W + 2;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    asm_state_t        state_q;
    asm_state_t        state_d;
    logic [CNT_W-1:0]  beat_cnt_q;
    logic [31:0]       ctag_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_merged;
    logic              ue_acc_q;
    logic              pe_acc_q;
    logic              beat_pe;
    logic              is_last;
    logic              commit;
    logic              proto_set;
    logic              fifo_ovf;
    logic [LINE_W-1:0] commit_line;
    logic [LINE_W-1:0] head_line;

    assign beat_pe = (l2b_sio_parity[1] != even_par16(l2b_sio_data[31:16]))
                   | (l2b_sio_parity[0] != even_par16(l2b_sio_data[15:0]));
    assign is_last = (beat_cnt_q == LAST_BEAT);

    always_ff @(posedge iol2clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (l2b_sio_ctag_vld) state_d = ST_DATA;
            ST_DATA: begin
                if (l2b_sio_ctag_vld) begin
                    state_d = ST_DATA;
                end else if (is_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A header during DATA restarts capture and is reported as a framing violation.
    always_comb begin
        commit    = 1'b0;
        proto_set = 1'b0;
        if (state_q == ST_DATA) begin
            if (l2b_sio_ctag_vld) begin
                proto_set = 1'b1;
            end else if (is_last) begin
                commit = 1'b1;
            end
        end
    end

    always_comb begin
        data_merged = data_q;
        data_merged[32*int'(beat_cnt_q) +: 32] = l2b_sio_data;
    end

    // The final beat goes straight into the committed line rather than through data_q.
    assign commit_line = {ctag_q, data_merged, ue_acc_q | l2b_sio_ue_err, pe_acc_q | beat_pe};

    always_ff @(posedge iol2clk) begin
        if (reset) begin
            ctag_q     <= '0;
            data_q     <= '0;
            beat_cnt_q <= '0;
            ue_acc_q   <= 1'b0;
            pe_acc_q   <= 1'b0;
        end else if (l2b_sio_ctag_vld) begin
            ctag_q     <= l2b_sio_data;
            pe_acc_q   <= beat_pe;
            ue_acc_q   <= 1'b0;
            beat_cnt_q <= '0;
        end else if (state_q == ST_DATA) begin
            data_q   <= data_merged;
            ue_acc_q <= ue_acc_q | l2b_sio_ue_err;
            pe_acc_q <= pe_acc_q | beat_pe;
            if (!is_last) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    // Clearing wins over a same-cycle set, so that event is not recorded.
    always_ff @(posedge iol2clk) begin
        if (reset) begin
            ovf_err   <= 1'b0;
            proto_err <= 1'b0;
        end else if (err_clr) begin
            ovf_err   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (fifo_ovf)  ovf_err   <= 1'b1;
            if (proto_set) proto_err <= 1'b1;
        end
    end

    l2b_sio_line_fifo #(
        .WIDTH (LINE_W)
    ) u_line_fifo (
        .iol2clk (iol2clk),
        .reset   (reset),
        .wr_en   (commit),
        .wr_data (commit_line),
        .rd_rdy  (out_rdy),
        .rd_vld  (out_vld),
        .rd_data (head_line),
        .ovf     (fifo_ovf)
    );

    assign out_ctag = head_line[LINE_W-1 -: 32];
    assign out_data = head_line[2 +: DATA_W];
    assign out_ue   = head_line[1];
    assign out_pe   = head_line[0];
    assign out_bank = 3'(BANK_ID);

endmodule

// File: tb/tb_l2b_sio_rtn_assembler.sv
// Directed bench for l2b_sio_rtn_assembler: stimulus pushes expected lines into a queue,
// an independent monitor pops and compares them whenever the DUT hands a line over.
module tb_l2b_sio_rtn_assembler;
    import l2_sio_pkg::*;

    localparam int NB   = L2_NUM_BEATS;
    localparam int BANK = 5;

    logic              iol2clk = 1'b0;
    logic              reset;
    logic              l2b_sio_ctag_vld;
    logic [31:0]       l2b_sio_data;
    logic [1:0]        l2b_sio_parity;
    logic              l2b_sio_ue_err;
    logic              out_vld;
    logic              out_rdy;
    logic [31:0]       out_ctag;
    logic [32*NB-1:0]  out_data;
    logic              out_ue;
    logic              out_pe;
    logic [2:0]        out_bank;
    logic              ovf_err;
    logic              proto_err;
    logic              err_clr;

    int    vectors     = 0;
    int    miscompares = 0;
    line_t expQ[$];

    always #5 iol2clk = ~iol2clk;

    l2b_sio_rtn_assembler #(
        .NUM_BEATS (NB),
        .BANK_ID   (BANK)
    ) dut (
        .iol2clk          (iol2clk),
        .reset            (reset),
        .l2b_sio_ctag_vld (l2b_sio_ctag_vld),
        .l2b_sio_data     (l2b_sio_data),
        .l2b_sio_parity   (l2b_sio_parity),
        .l2b_sio_ue_err   (l2b_sio_ue_err),
        .out_vld          (out_vld),
        .out_rdy          (out_rdy),
        .out_ctag         (out_ctag),
        .out_data         (out_data),
        .out_ue           (out_ue),
        .out_pe           (out_pe),
        .out_bank         (out_bank),
        .ovf_err          (ovf_err),
        .proto_err        (proto_err),
        .err_clr          (err_clr)
    );

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One cycle of input; the DUT samples it on the next rising edge.
    task automatic applyStimulus(input logic vld, input logic [31:0] d, input logic ue, input logic badPar);
        l2b_sio_ctag_vld = vld;
        l2b_sio_data     = d;
        l2b_sio_ue_err   = ue;
        l2b_sio_parity   = {(^d[31:16]) ^ badPar, ^d[15:0]};
        @(posedge iol2clk);
        #1;
    endtask

    task automatic driveIdle(input int n);
        repeat (n) applyStimulus(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b1);
    endtask

    // peBeat: -1 none, 0..NB-1 data beat, NB header. abortAt: stop before that data beat.
    task automatic sendLine(input logic [31:0] ctag, input logic [31:0] base, input int ueBeat,
                            input int peBeat, input bit doExpect, input int abortAt, input bit rdyOnLast);
        line_t e;
        e.ctag = ctag;
        e.ue   = (ueBeat >= 0);
        e.pe   = (peBeat >= 0);
        e.data = '0;
        for (int k = 0; k < NB; k++) e.data[32*k +: 32] = base + 32'(k);
        if (doExpect) expQ.push_back(e);
        applyStimulus(1'b1, ctag, 1'b0, peBeat == NB);
        for (int k = 0; k < NB; k++) begin
            if (k == abortAt) return;
            if (rdyOnLast && k == NB - 1) out_rdy = 1'b1;
            applyStimulus(1'b0, base + 32'(k), ueBeat == k, peBeat == k);
        end
        if (rdyOnLast) out_rdy = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            @(posedge iol2clk);
            #1;
            n++;
        end
        checkOutput("drain", 512'(expQ.size()), 512'd0);
    endtask

    always @(negedge iol2clk) begin
        if (reset === 1'b0 && out_vld === 1'b1 && out_rdy === 1'b1) begin
            if (expQ.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_line: got ctag %0h, expected no line", out_ctag);
            end else begin
                line_t e;
                e = expQ.pop_front();
                checkOutput("line_ctag", 512'(out_ctag), 512'(e.ctag));
                checkOutput("line_data", out_data, e.data);
                checkOutput("line_ue", 512'(out_ue), 512'(e.ue));
                checkOutput("line_pe", 512'(out_pe), 512'(e.pe));
                checkOutput("line_bank", 512'(out_bank), 512'(BANK));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b1;
        out_rdy = 1'b0;
        err_clr = 1'b0;
        l2b_sio_ctag_vld = 1'b0;
        l2b_sio_data = '0;
        l2b_sio_parity = '0;
        l2b_sio_ue_err = 1'b0;
        repeat (3) @(posedge iol2clk);
        #1;
        reset = 1'b0;
        checkOutput("rst_vld", 512'(out_vld), 512'd0);
        checkOutput("rst_ctag", 512'(out_ctag), 512'd0);
        checkOutput("rst_data", out_data, 512'd0);
        checkOutput("rst_ue", 512'(out_ue), 512'd0);
        checkOutput("rst_pe", 512'(out_pe), 512'd0);
        checkOutput("rst_ovf", 512'(ovf_err), 512'd0);
        checkOutput("rst_proto", 512'(proto_err), 512'd0);

        $display("[TB] single line latency");
        out_rdy = 1'b1;
        driveIdle(2);
        sendLine(32'hA5A5_0001, 32'h0, -1, -1, 1'b1, NB - 1, 1'b0);
        checkOutput("t1_vld_T16", 512'(out_vld), 512'd0);
        applyStimulus(1'b0, 32'h0000_000F, 1'b0, 1'b0);
        checkOutput("t1_vld_T17", 512'(out_vld), 512'd1);
        checkOutput("t1_ctag", 512'(out_ctag), 512'hA5A5_0001);
        checkOutput("t1_beat15", 512'(out_data[511:480]), 512'h0000_000F);
        driveIdle(2);

        $display("[TB] ue and parity accumulation");
        sendLine(32'h1111_0002, 32'h100, 7, -1, 1'b1, -1, 1'b0);
        sendLine(32'h2222_0003, 32'h200, -1, 3, 1'b1, -1, 1'b0);
        sendLine(32'h3333_0004, 32'h300, -1, NB, 1'b1, -1, 1'b0);
        driveIdle(1);
        waitDrain(10);

        $display("[TB] overflow with consumer stalled");
        out_rdy = 1'b0;
        sendLine(32'h4444_0005, 32'h400, -1, -1, 1'b1, -1, 1'b0);
        sendLine(32'h5555_0006, 32'h500, -1, -1, 1'b1, -1, 1'b0);
        checkOutput("t3_ovf_before", 512'(ovf_err), 512'd0);
        sendLine(32'h6666_0007, 32'h600, -1, -1, 1'b0, -1, 1'b0);
        checkOutput("t3_ovf_set", 512'(ovf_err), 512'd1);
        driveIdle(1);
        checkOutput("t3_ovf_sticky", 512'(ovf_err), 512'd1);
        out_rdy = 1'b1;
        waitDrain(10);
        driveIdle(1);
        checkOutput("t3_empty", 512'(out_vld), 512'd0);
        err_clr = 1'b1;
        driveIdle(1);
        err_clr = 1'b0;
        checkOutput("t3_ovf_clr", 512'(ovf_err), 512'd0);

        $display("[TB] commit and pop together at full");
        out_rdy = 1'b0;
        sendLine(32'h7777_0008, 32'h700, -1, -1, 1'b1, -1, 1'b0);
        sendLine(32'h8888_0009, 32'h800, -1, -1, 1'b1, -1, 1'b0);
        sendLine(32'h9999_000A, 32'h900, 2, -1, 1'b1, -1, 1'b1);
        checkOutput("t4_no_ovf", 512'(ovf_err), 512'd0);
        checkOutput("t4_still_vld", 512'(out_vld), 512'd1);
        out_rdy = 1'b1;
        waitDrain(10);
        driveIdle(1);
        checkOutput("t4_empty", 512'(out_vld), 512'd0);

        $display("[TB] header mid-line");
        sendLine(32'hBAD0_000B, 32'hB00, -1, -1, 1'b0, 5, 1'b0);
        checkOutput("t5_proto_before", 512'(proto_err), 512'd0);
        sendLine(32'hC0DE_000C, 32'hC00, -1, -1, 1'b1, -1, 1'b0);
        checkOutput("t5_proto_set", 512'(proto_err), 512'd1);
        driveIdle(1);
        waitDrain(10);
        err_clr = 1'b1;
        driveIdle(1);
        err_clr = 1'b0;
        checkOutput("t5_proto_clr", 512'(proto_err), 512'd0);

        $display("[TB] clear beats a same-cycle set");
        sendLine(32'hBAD0_000D, 32'hD00, -1, -1, 1'b0, 3, 1'b0);
        err_clr = 1'b1;
        sendLine(32'hBAD0_000E, 32'hE00, -1, -1, 1'b0, 0, 1'b0);
        err_clr = 1'b0;
        checkOutput("t5b_proto_lost", 512'(proto_err), 512'd0);
        sendLine(32'hF00D_000F, 32'hF00, -1, -1, 1'b1, -1, 1'b0);
        checkOutput("t5b_proto_set", 512'(proto_err), 512'd1);
        driveIdle(1);
        waitDrain(10);
        err_clr = 1'b1;
        driveIdle(1);
        err_clr = 1'b0;

        $display("[TB] reset mid-line");
        out_rdy = 1'b0;
        sendLine(32'h1234_0010, 32'h1000, -1, -1, 1'b0, -1, 1'b0);
        sendLine(32'h1234_0011, 32'h1100, -1, -1, 1'b0, 8, 1'b0);
        reset = 1'b1;
        driveIdle(1);
        reset = 1'b0;
        checkOutput("t6_vld_after_rst", 512'(out_vld), 512'd0);
        checkOutput("t6_ctag_after_rst", 512'(out_ctag), 512'd0);
        out_rdy = 1'b1;
        sendLine(32'h5678_0012, 32'h1200, -1, -1, 1'b1, -1, 1'b0);
        driveIdle(1);
        waitDrain(10);
        driveIdle(2);
        checkOutput("final_empty", 512'(out_vld), 512'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
